// File: rtl/mod_preprocess.sv
// Montgomery pre-processing: T = (M * 2^SHIFT) mod N by iterated modular doubling,
// BPC doublings per clock, with a start/busy/finish handshake.
module mod_preprocess #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned SHIFT = 256,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] N_i,
    input  logic [WIDTH-1:0] M_i,
    output logic [WIDTH-1:0] T_o,
    output logic             busy_o,
    output logic             finish_o,
    output logic             err_o
);

    if (BPC < 1 || SHIFT < 1 || (SHIFT % BPC) != 0) begin : g_param_check
        $error("mod_preprocess: SHIFT must be >= 1 and a multiple of BPC");
    end

    localparam int unsigned     CW       = $clog2(SHIFT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SHIFT - BPC);
    localparam logic [CW-1:0]   CNT_INC  = CW'(BPC);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   acc_step;
    logic [CW-1:0]    cnt_q;
    logic             last_step;
    logic [WIDTH-1:0] m_red;

    assign last_step = (cnt_q == CNT_LAST);
    // Initial reduction only needs one subtraction because M < 2N.
    assign m_red     = (M_i >= N_i) ? M_i - N_i : M_i;

    // BPC chained double-and-reduce steps; acc < N keeps the shifted value inside WIDTH+1 bits.
    always_comb begin
        logic [WIDTH:0] x;
        x        = '0;
        acc_step = acc_q;
        for (int unsigned i = 0; i < BPC; i++) begin
            x        = {acc_step[WIDTH-1:0], 1'b0};
            acc_step = (x >= {1'b0, n_q}) ? x - {1'b0, n_q} : x;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = (N_i == '0) ? DONE : RUN;
            RUN:  if (last_step) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state == RUN);
        finish_o = (state == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            T_o   <= '0;
            err_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        n_q   <= N_i;
                        cnt_q <= '0;
                        acc_q <= {1'b0, m_red};
                        err_o <= (N_i == '0);
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_INC;
                    if (last_step) T_o <= acc_step[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_preprocess.sv
// Self-checking bench for mod_preprocess: three instances (8b/1 step, 8b/2 steps, 256b/1 step)
// checked against an arithmetic model of (M * 2^SHIFT) mod N.
module tb_mod_preprocess;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   start = '0;
    logic [255:0] n_bus = '0;
    logic [255:0] m_bus = '0;

    logic [7:0]   t0, t1;
    logic [255:0] t2;
    logic [2:0]   busy, fin, err;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [255:0] last_t [3];

    always #5 clk = ~clk;

    mod_preprocess #(.WIDTH(8), .SHIFT(8), .BPC(1)) u_d0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .N_i(n_bus[7:0]), .M_i(m_bus[7:0]),
        .T_o(t0), .busy_o(busy[0]), .finish_o(fin[0]), .err_o(err[0]));

    mod_preprocess #(.WIDTH(8), .SHIFT(8), .BPC(2)) u_d1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .N_i(n_bus[7:0]), .M_i(m_bus[7:0]),
        .T_o(t1), .busy_o(busy[1]), .finish_o(fin[1]), .err_o(err[1]));

    mod_preprocess #(.WIDTH(256), .SHIFT(256), .BPC(1)) u_d2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .N_i(n_bus), .M_i(m_bus),
        .T_o(t2), .busy_o(busy[2]), .finish_o(fin[2]), .err_o(err[2]));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int d, output logic [255:0] t, output logic b, output logic f,
                          output logic e);
        case (d)
            0:       t = {248'd0, t0};
            1:       t = {248'd0, t1};
            default: t = t2;
        endcase
        b = busy[d];
        f = fin[d];
        e = err[d];
    endtask

    function automatic logic [255:0] ref_t(input logic [255:0] n, input logic [255:0] m,
                                           input int shift);
        logic [511:0] t;
        logic [511:0] nn;
        nn = {256'd0, n};
        t  = {256'd0, m} % nn;
        for (int i = 0; i < shift; i++) t = (t << 1) % nn;
        return t[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge while DUT d is idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input int d, input logic [255:0] n, input logic [255:0] m,
                          input bit toggle);
        int           shift, bpc, cyc, busy_cnt, exp_lat, exp_busy;
        logic [255:0] exp_t, t;
        logic         b, f, e, exp_err;
        shift = (d == 2) ? 256 : 8;
        bpc   = (d == 1) ? 2 : 1;
        if (n == '0) begin
            exp_err = 1'b1; exp_t = last_t[d]; exp_lat = 1; exp_busy = 0;
        end else begin
            exp_err = 1'b0; exp_t = ref_t(n, m, shift);
            exp_lat = shift / bpc + 1; exp_busy = shift / bpc;
        end
        n_bus = n; m_bus = m; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        cyc = 1; busy_cnt = 0;
        forever begin
            sample(d, t, b, f, e);
            if (f || cyc >= 400) break;
            if (b) busy_cnt++;
            if (toggle) begin
                start[d] = 1'($urandom % 2);
                n_bus    = rand256();
                m_bus    = rand256();
            end
            @(negedge clk);
            cyc++;
        end
        start[d] = 1'b0;
        chk("finish_seen", {255'd0, f}, 256'd1);
        chk("latency", cyc, exp_lat);
        chk("result", t, exp_t);
        chk("err", {255'd0, e}, {255'd0, exp_err});
        chk("busy_cycles", busy_cnt, exp_busy);
        last_t[d] = exp_t;
        @(negedge clk);
        sample(d, t, b, f, e);
        chk("finish_pulse_end", {255'd0, f}, 256'd0);
        chk("busy_after_done", {255'd0, b}, 256'd0);
        chk("result_held", t, exp_t);
    endtask

    initial begin
        logic [255:0] t, n, m;
        logic         b, f, e;
        int           seen;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, t, b, f, e);
            chk("reset_t", t, '0);
            chk("reset_flags", {253'd0, b, f, e}, '0);
            last_t[d] = '0;
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 256'd13, 256'd5, 1'b0);
        run_op(0, 256'd13, 256'd20, 1'b0);
        run_op(0, 256'd255, 256'd254, 1'b0);
        run_op(1, 256'd13, 256'd5, 1'b0);
        run_op(1, 256'd255, 256'd254, 1'b0);
        run_op(0, 256'd0, 256'd7, 1'b0);
        run_op(0, 256'd13, 256'd5, 1'b0);
        run_op(0, 256'd13, 256'd5, 1'b1);

        n = '1;
        n = n - 256'd188;
        run_op(2, n, 256'd1, 1'b0);
        chk("big_fixed_value", last_t[2], 256'd189);
        run_op(2, 256'd0, 256'd3, 1'b0);

        for (int i = 0; i < 12; i++) begin
            n = 256'($urandom_range(1, 255));
            m = 256'($urandom % (2 * n[15:0]));
            if (m > 256'd255) m = 256'd255;
            run_op(i % 2, n, m, 1'(i % 3 == 0));
        end
        for (int i = 0; i < 2; i++) begin
            n = rand256();
            n[255] = 1'b1;
            run_op(2, n, rand256(), 1'b0);
        end

        // Abort mid-run: outputs clear asynchronously and no finish pulse follows.
        n_bus = 256'd13; m_bus = 256'd5; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        sample(0, t, b, f, e);
        chk("abort_t", t, '0);
        chk("abort_flags", {253'd0, b, f, e}, '0);
        sample(2, t, b, f, e);
        chk("abort_t_wide", t, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_t[d] = '0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (fin[0]) seen++;
        end
        chk("no_finish_after_abort", seen, 0);
        run_op(0, 256'd13, 256'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_preprocess.md
Name: mod_preprocess

Overview:
- Clocked, parametrised Montgomery pre-processing unit for the RSA datapath.
- Computes T = (M * 2^SHIFT) mod N by iterated modular doubling: double, then conditionally subtract N.
- Processes BPC doublings per clock and uses a start/busy/finish handshake.
- Sits between operand load and the Montgomery multiplier, which consumes T_o.

Parameters:
- WIDTH, 256, operand width in bits for N, M and T.
- SHIFT, 256, number of modular doublings (exponent of 2); must be >= 1.
- BPC, 1, doublings per clock; must divide SHIFT exactly (elaboration-time check).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle request; sampled only in IDLE.
- N_i  input  WIDTH  modulus; sampled in the start cycle.
- M_i  input  WIDTH  message; sampled in the start cycle; must be < 2N.
- T_o  output  WIDTH  result, held until the next accepted start.
- busy_o  output  1  high from the cycle after start acceptance until finish_o.
- finish_o  output  1  one-cycle pulse when T_o is valid.
- err_o  output  1  set with finish_o when N_i == 0; held until the next accepted start.

Behaviour:
- Reset (async, rst_i = 1):
  - State goes to IDLE.
  - T_o = 0, busy_o = 0, finish_o = 0, err_o = 0, internal accumulator = 0, counter = 0.
  - Reset mid-operation aborts the computation; no finish_o is produced.
- State IDLE:
  - On start_i = 1, latch N.
  - Accumulator acc (WIDTH+1 bits) <= (M_i >= N_i) ? M_i - N_i : M_i. This is the initial reduction, valid for M < 2N.
  - Clear counter and err_o; go to RUN.
  - If N_i == 0, go to DONE instead with err_o <= 1; T_o is left unchanged.
- State RUN:
  - Each cycle, apply BPC chained steps combinationally: x = acc << 1 (WIDTH+1 bits); acc' = (x >= N) ? x - N : x.
  - The comparison is >=, never >.
  - Counter increments by BPC each cycle.
  - When the counter reaches SHIFT - BPC in the current cycle, write the final acc to T_o (low WIDTH bits) and go to DONE.
- State DONE:
  - finish_o = 1 for exactly this one cycle; busy_o = 0.
  - Next state is IDLE.
  - start_i asserted in DONE is ignored.
- Latency:
  - Start accepted at edge 0.
  - T_o valid and finish_o high in the cycle after edge SHIFT/BPC.
  - Example: BPC=1, SHIFT=256 gives finish_o 257 cycles after start.
- Invariants:
  - Accumulator stays < N after every step, so the WIDTH+1-bit intermediate never overflows, including for N close to 2^WIDTH.
  - busy_o = 1 throughout RUN.
  - start_i during RUN is ignored; the operand latch is not disturbed.
- Out-of-contract input (M >= 2N): T_o is undefined but finish_o timing is unchanged. The block must not hang.
- Back-to-back operation: a new start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- WIDTH=8, SHIFT=8, BPC=1; N=13, M=5, start -> finish_o exactly 9 cycles after start; T_o=6; err_o=0; busy_o high for 8 cycles.
- WIDTH=8, SHIFT=8, BPC=2; N=13, M=5 -> finish_o after 5 cycles; T_o=6.
- WIDTH=8, SHIFT=8; N=13, M=20 (initial reduction) -> T_o=11. Then N=255, M=254 (9-bit intermediate) -> T_o=254.
- Default parameters; N=2^256-189, M=1 -> finish_o after 257 cycles; T_o=189.
- N=0 -> finish_o 1 cycle after start, err_o=1, T_o unchanged. The following valid start clears err_o.
- Start N=13, M=5 and toggle start_i during RUN -> result and timing unaffected.
- Assert rst_i at cycle 4 of RUN -> all outputs 0 immediately, no finish_o. A restart then completes normally.
